// File: rtl/fetch_pkg.sv
// Shared fetch types and constants.
// Optional prebuffer build: define FETCH_PREBUF_EN.
package fetch_pkg;

  localparam int PC_W       = 32;
  localparam int WORD_BYTES = 4;

  localparam logic [PC_W-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]     word;
    logic [PC_W-1:0] pc;
  } fetch_ent_t;

  function automatic logic [PC_W-1:0] align_pc(
    input logic [PC_W-1:0] a
  );
    return {a[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {word, pc} prebuffer with flush.
// Present only when FETCH_PREBUF_EN is defined.
`ifdef FETCH_PREBUF_EN
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_flush,
  input  logic       i_push,
  input  fetch_ent_t i_data,
  input  logic       i_pop,
  output fetch_ent_t o_data,
  output logic [1:0] o_cnt
);

  fetch_ent_t r_mem [2];
  logic       r_wp;
  logic       r_rp;
  logic [1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (i_flush) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= ~r_wp;
      end
      if (i_pop) begin
        r_rp <= ~r_rp;
      end
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_data = r_mem[r_rp];
  assign o_cnt  = r_cnt;

endmodule
`endif

// File: rtl/inst_fetch.sv
// Instruction fetch stage: memory request FSM with redirect handling.
// Define FETCH_PREBUF_EN to add a 2-entry prebuffer toward the decoder.
module inst_fetch
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_word,
  output logic [PC_W-1:0] inst_pc,
  output logic [PC_W-1:0] inst_pc_next,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc
);

  fetch_state_e    r_state;
  fetch_state_e    w_next;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_old;
  logic            w_take;
  logic            w_hs;
  logic            w_stall;

  assign w_take = (r_state == REQ) && imem_ack && !redirect;
  assign w_hs   = inst_valid && inst_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: w_next = REQ;
      REQ: begin
        if (redirect)
          w_next = imem_ack ? REQ : DROP;
        else if (imem_ack && w_stall)
          w_next = HOLD;
      end
      HOLD: if (redirect || w_hs) w_next = REQ;
      DROP: if (imem_ack) w_next = REQ;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (r_state == REQ) || (r_state == DROP);
    imem_addr = (r_state == DROP) ? r_old : r_pc;
  end

  // r_pc doubles as the recorded target while DROP drains the old request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= RESET_PC;
      r_old <= RESET_PC;
    end else begin
      if (redirect)
        r_pc <= align_pc(redirect_pc);
      else if (w_take)
        r_pc <= r_pc + PC_W'(WORD_BYTES);
      if ((r_state == REQ) && redirect && !imem_ack)
        r_old <= r_pc;
    end
  end

  assign inst_pc_next = inst_pc + PC_W'(WORD_BYTES);

`ifdef FETCH_PREBUF_EN
  fetch_ent_t w_head;
  fetch_ent_t w_in;
  logic [1:0] w_cnt;

  assign w_in    = '{word: imem_rdata, pc: r_pc};
  assign w_stall = (w_cnt == 2'd1) && !w_hs;

  fetch_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect),
    .i_push  (w_take),
    .i_data  (w_in),
    .i_pop   (w_hs),
    .o_data  (w_head),
    .o_cnt   (w_cnt)
  );

  assign inst_valid = (w_cnt != 2'd0);
  assign inst_word  = w_head.word;
  assign inst_pc    = w_head.pc;
`else
  logic            r_valid;
  logic [31:0]     r_word;
  logic [PC_W-1:0] r_ipc;

  assign w_stall = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_word  <= '0;
      r_ipc   <= '0;
    end else if (w_take) begin
      r_valid <= 1'b1;
      r_word  <= imem_rdata;
      r_ipc   <= r_pc;
    end else if (redirect || w_hs) begin
      r_valid <= 1'b0;
    end
  end

  assign inst_valid = r_valid;
  assign inst_word  = r_word;
  assign inst_pc    = r_ipc;
`endif

endmodule
